// File: rtl/exec_ctrl_fsm_if.sv
// Control bundle between the exec-stage controller (master) and the datapath/memory (slave).
// Signal names follow the existing datapath so the two sides plug together unchanged.
interface exec_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic [2:0] ALUCntrl;
  logic       ALUSrc;
  logic       jl;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic       wb_sel;
  logic       bus_err;
  logic       illegal;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output ALUCntrl, ALUSrc, jl, ir_we, pc_we, pc_src, mem_rd, mem_wr,
    output reg_we, reg_dst, wb_sel, bus_err, illegal
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  ALUCntrl, ALUSrc, jl, ir_we, pc_we, pc_src, mem_rd, mem_wr,
    input  reg_we, reg_dst, wb_sel, bus_err, illegal
  );
endinterface

// File: rtl/exec_ctrl_fsm.sv
// Multi-cycle controller: FETCH -> DECODE -> EXEC -> MEM -> WB with memory handshake,
// memory-timeout and illegal-instruction traps. Outputs decode from state, latched class and inputs.
module exec_ctrl_fsm #(
  parameter int unsigned WAIT_LIMIT = 8
) (
  input logic             clk,
  input logic             reset_n,
  exec_ctrl_fsm_if.master bus
);

  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_LIMIT - 1);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpJal  = 6'h03;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpXori = 6'h0E;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSlt  = 6'h2A;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluXor = 3'b010;
  localparam logic [2:0] AluSlt = 3'b011;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StTrap
  } state_e;

  typedef enum logic [2:0] {
    InsLw, InsSw, InsBne, InsAddi, InsXori, InsAdd, InsSub, InsSlt
  } ins_e;

  state_e          state_q, state_d;
  ins_e            ins_q, ins_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
  logic            illegal_q, illegal_d;

  ins_e dec_ins;
  logic dec_ok;

  logic [2:0] alu_ctrl;
  logic       alu_src;
  logic       jl;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic       wb_sel;

  // Instruction classes that continue past DECODE.
  always_comb begin
    dec_ok  = 1'b1;
    dec_ins = InsAdd;
    case (bus.opcode)
      OpLw:    dec_ins = InsLw;
      OpSw:    dec_ins = InsSw;
      OpBne:   dec_ins = InsBne;
      OpAddi:  dec_ins = InsAddi;
      OpXori:  dec_ins = InsXori;
      OpR: begin
        case (bus.funct)
          FnAdd:   dec_ins = InsAdd;
          FnSub:   dec_ins = InsSub;
          FnSlt:   dec_ins = InsSlt;
          default: dec_ok  = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // ALU setup is a pure function of the latched class; held from EXEC through WB.
  logic [2:0] cls_alu;
  logic       cls_src;
  always_comb begin
    cls_alu = AluAdd;
    cls_src = 1'b1;
    unique case (ins_q)
      InsLw, InsSw, InsAddi: begin cls_alu = AluAdd; cls_src = 1'b0; end
      InsXori:               begin cls_alu = AluXor; cls_src = 1'b0; end
      InsBne:                begin cls_alu = AluSub; cls_src = 1'b1; end
      InsAdd:                begin cls_alu = AluAdd; cls_src = 1'b1; end
      InsSub:                begin cls_alu = AluSub; cls_src = 1'b1; end
      InsSlt:                begin cls_alu = AluSlt; cls_src = 1'b1; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    illegal_d = illegal_q;
    alu_ctrl  = AluAdd;
    alu_src   = 1'b1;
    jl        = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 2'b00;
    wb_sel    = 1'b0;

    case (state_q)
      StFetch: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end else if (cnt_q == CntLast) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: begin
        if (bus.opcode == OpJ) begin
          pc_we   = 1'b1;
          pc_src  = 2'b10;
          state_d = StFetch;
        end else if (bus.opcode == OpJal) begin
          jl      = 1'b1;
          reg_we  = 1'b1;
          reg_dst = 2'b10;
          pc_we   = 1'b1;
          pc_src  = 2'b10;
          state_d = StFetch;
        end else if (bus.opcode == OpR && bus.funct == FnJr) begin
          pc_we   = 1'b1;
          pc_src  = 2'b11;
          state_d = StFetch;
        end else if (dec_ok) begin
          ins_d   = dec_ins;
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = StTrap;
        end
      end
      StExec: begin
        alu_ctrl = cls_alu;
        alu_src  = cls_src;
        if (ins_q == InsBne) begin
          pc_we   = ~bus.alu_zero;
          pc_src  = 2'b01;
          state_d = StFetch;
        end else if (ins_q == InsLw || ins_q == InsSw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        alu_ctrl = cls_alu;
        alu_src  = cls_src;
        mem_rd   = (ins_q == InsLw);
        mem_wr   = (ins_q != InsLw);
        if (bus.mem_ready) begin
          state_d = (ins_q == InsLw) ? StWb : StFetch;
        end else if (cnt_q == CntLast) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        alu_ctrl = cls_alu;
        alu_src  = cls_src;
        reg_we   = 1'b1;
        reg_dst  = (ins_q == InsAdd || ins_q == InsSub || ins_q == InsSlt) ? 2'b01 : 2'b00;
        wb_sel   = (ins_q == InsLw);
        state_d  = StFetch;
      end
      default: begin
        state_d = StTrap;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Strobes must not glitch out while reset is held, even though FETCH is the reset state.
    if (!reset_n) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      reg_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      ins_q     <= InsAdd;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ALUCntrl = alu_ctrl;
  assign bus.ALUSrc   = alu_src;
  assign bus.jl       = jl;
  assign bus.ir_we    = ir_we;
  assign bus.pc_we    = pc_we;
  assign bus.pc_src   = pc_src;
  assign bus.mem_rd   = mem_rd;
  assign bus.mem_wr   = mem_wr;
  assign bus.reg_we   = reg_we;
  assign bus.reg_dst  = reg_dst;
  assign bus.wb_sel   = wb_sel;
  assign bus.bus_err  = bus_err_q;
  assign bus.illegal  = illegal_q;

endmodule
